mx_window_feeder: RTL and testbench

Feeds the signed max-pooling unit from a raster-order feature-map stream and collects its results.
- Buffers one even row and pairs it with the following odd row to form 2x2, stride-2 windows.
- Issues the four window elements over the pooling unit's one-cycle load pulse protocol, then pulses `exe` ready and captures the pooled result.
- Sits between the convolution output stream and the next layer's input.

---
 rtl/pkg_parameters.sv | 20 ++
 rtl/mx_line_buffer.sv | 41 ++++
 rtl/mx_window_feeder.sv | 220 ++++++++++++++++++++++
 tb/tb_mx_window_feeder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_parameters.sv
// Shared state encoding and cycle constants for the max-pool window feeder.
package pkg_parameters;

   typedef enum logic [2:0] {
      MXF_INIT,
      MXF_EVEN,
      MXF_ODD,
      MXF_ISSUE,
      MXF_DRAIN,
      MXF_RECOVER
   } mxf_state_e;

   localparam int unsigned MXF_INIT_CYC    = 2;
   localparam int unsigned MXF_GAP_CYC     = 1;
   localparam int unsigned MXF_RECOVER_CYC = 2;
   localparam int unsigned MXF_ELEMS       = 4;
   localparam int unsigned MXF_CNT_W       = 2;
   localparam int unsigned MXF_ELEM_W      = $clog2(MXF_ELEMS);

endpackage

// File: rtl/mx_line_buffer.sv
// One-row line buffer with a registered read port; the read register can also
// be loaded from a bypass input so it serves as the single element output flop.
module mx_line_buffer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              byp_en_i,
   input  logic [DATA_W-1:0] byp_data_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_d, rd_data_q;

   // Storage is not reset; contents are only read after a full even row is written.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (byp_en_i)     rd_data_d = byp_data_i;
      else if (rd_en_i) rd_data_d = mem[rd_addr_i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mx_window_feeder.sv
// Turns a raster pixel stream into 2x2 stride-2 windows for the max-pooling
// unit's load/exe pulse protocol and holds each pooled result for downstream.
module mx_window_feeder
   import pkg_parameters::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 8,
   parameter int unsigned IMG_H  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pix_valid_i,
   input  logic [DATA_W-1:0] pix_data_i,
   output logic              pix_ready_o,
   output logic              mx_load_valid_o,
   output logic [DATA_W-1:0] mx_load_data_o,
   output logic              mx_exe_ready_o,
   input  logic              mx_exe_valid_i,
   input  logic [DATA_W-1:0] mx_exe_data_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   input  logic              out_ready_i
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);

   mxf_state_e              state_d, state_q;
   logic [MXF_CNT_W-1:0]    cnt_d, cnt_q;
   logic [MXF_ELEM_W-1:0]   elem_d, elem_q;
   logic [COL_W-1:0]        col_d, col_q;
   logic [ROW_W-1:0]        row_d, row_q;
   logic [DATA_W-1:0]       bl_d, bl_q, br_d, br_q;
   logic                    pix_ready_d, pix_ready_q;
   logic                    load_valid_d, load_valid_q;
   logic                    exe_ready_d, exe_ready_q;
   logic                    out_valid_d, out_valid_q;
   logic [DATA_W-1:0]       out_data_d, out_data_q;
   logic                    out_last_d, out_last_q;

   logic                    pix_acc, col_last, row_last;
   logic                    lb_wr_en, lb_rd_en, lb_byp_en;
   logic [COL_W-1:0]        lb_rd_addr;
   logic [DATA_W-1:0]       lb_byp_data, lb_rd_data;

   mx_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
   ) u_line_buffer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (lb_wr_en),
      .wr_addr_i  (col_q),
      .wr_data_i  (pix_data_i),
      .rd_en_i    (lb_rd_en),
      .rd_addr_i  (lb_rd_addr),
      .byp_en_i   (lb_byp_en),
      .byp_data_i (lb_byp_data),
      .rd_data_o  (lb_rd_data)
   );

   // Next-state, counters, element sequencing and result register.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      elem_d       = elem_q;
      col_d        = col_q;
      row_d        = row_q;
      bl_d         = bl_q;
      br_d         = br_q;
      load_valid_d = 1'b0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      lb_wr_en     = 1'b0;
      lb_rd_en     = 1'b0;
      lb_rd_addr   = col_q;
      lb_byp_en    = 1'b0;
      lb_byp_data  = bl_q;
      pix_acc      = pix_valid_i && pix_ready_q;
      col_last     = (col_q == COL_W'(IMG_W - 1));
      row_last     = (row_q == ROW_W'(IMG_H - 1));

      if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

      case (state_q)
         MXF_INIT: begin
            if (cnt_q == MXF_CNT_W'(MXF_INIT_CYC - 1)) begin
               cnt_d   = '0;
               state_d = MXF_EVEN;
            end else begin
               cnt_d = cnt_q + MXF_CNT_W'(1);
            end
         end
         MXF_EVEN: begin
            if (pix_acc) begin
               lb_wr_en = 1'b1;
               if (col_last) begin
                  col_d   = '0;
                  row_d   = row_q + ROW_W'(1);
                  state_d = MXF_ODD;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         MXF_ODD: begin
            if (pix_acc) begin
               if (!col_q[0]) begin
                  bl_d  = pix_data_i;
                  col_d = col_q + COL_W'(1);
               end else begin
                  // Window complete: first element read is launched right here.
                  br_d         = pix_data_i;
                  cnt_d        = '0;
                  elem_d       = '0;
                  load_valid_d = 1'b1;
                  lb_rd_en     = 1'b1;
                  lb_rd_addr   = col_q - COL_W'(1);
                  state_d      = MXF_ISSUE;
               end
            end
         end
         MXF_ISSUE: begin
            if (cnt_q == MXF_CNT_W'(MXF_GAP_CYC)) begin
               if (elem_q == MXF_ELEM_W'(MXF_ELEMS - 1)) begin
                  state_d = MXF_DRAIN;
               end else begin
                  elem_d       = elem_q + MXF_ELEM_W'(1);
                  cnt_d        = '0;
                  load_valid_d = 1'b1;
                  case (elem_q)
                     MXF_ELEM_W'(0): lb_rd_en = 1'b1;
                     MXF_ELEM_W'(1): lb_byp_en = 1'b1;
                     default: begin
                        lb_byp_en   = 1'b1;
                        lb_byp_data = br_q;
                     end
                  endcase
               end
            end else begin
               cnt_d = cnt_q + MXF_CNT_W'(1);
            end
         end
         MXF_DRAIN: begin
            if (mx_exe_valid_i) begin
               out_valid_d = 1'b1;
               out_data_d  = mx_exe_data_i;
               out_last_d  = row_last && col_last;
               cnt_d       = '0;
               state_d     = MXF_RECOVER;
            end
         end
         MXF_RECOVER: begin
            if (cnt_q == MXF_CNT_W'(MXF_RECOVER_CYC - 1)) begin
               cnt_d = '0;
               if (!col_last) begin
                  col_d   = col_q + COL_W'(1);
                  state_d = MXF_ODD;
               end else begin
                  col_d   = '0;
                  row_d   = row_last ? '0 : row_q + ROW_W'(1);
                  state_d = MXF_EVEN;
               end
            end else begin
               cnt_d = cnt_q + MXF_CNT_W'(1);
            end
         end
         default: state_d = MXF_INIT;
      endcase

      // Odd-column pixels wait until the single result slot is free.
      pix_ready_d = (state_d == MXF_EVEN) ||
                    ((state_d == MXF_ODD) && (!col_d[0] || !out_valid_d));
      exe_ready_d = (state_d == MXF_DRAIN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= MXF_INIT;
         cnt_q        <= '0;
         elem_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         bl_q         <= '0;
         br_q         <= '0;
         pix_ready_q  <= 1'b0;
         load_valid_q <= 1'b0;
         exe_ready_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         elem_q       <= elem_d;
         col_q        <= col_d;
         row_q        <= row_d;
         bl_q         <= bl_d;
         br_q         <= br_d;
         pix_ready_q  <= pix_ready_d;
         load_valid_q <= load_valid_d;
         exe_ready_q  <= exe_ready_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
      end
   end

   assign pix_ready_o     = pix_ready_q;
   assign mx_load_valid_o = load_valid_q;
   assign mx_load_data_o  = lb_rd_data;
   assign mx_exe_ready_o  = exe_ready_q;
   assign out_valid_o     = out_valid_q;
   assign out_data_o      = out_data_q;
   assign out_last_o      = out_last_q;

endmodule

// File: tb/tb_mx_window_feeder.sv
// Directed bench for mx_window_feeder on a 4x4 map, with a behavioural
// signed max-pooling unit answering the load/exe pulse protocol.
module tb_mx_window_feeder;

   localparam int unsigned DW = 8;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 4;

   typedef logic [7:0] map_t [16];

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready_o;
   logic          mx_load_valid_o;
   logic [DW-1:0] mx_load_data_o;
   logic          mx_exe_ready_o;
   logic          mx_exe_valid = 1'b0;
   logic [DW-1:0] mx_exe_data  = '0;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic          out_last_o;
   logic          out_ready;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   int unsigned cyc      = 0;
   logic [7:0]  out_d   [512];
   logic        out_l   [512];
   int unsigned load_c  [512];
   logic [7:0]  load_d  [512];
   int unsigned acc_c   [512];
   int unsigned exe_c   [512];
   int unsigned orise_c [512];
   int unsigned n_out = 0, n_load = 0, n_acc = 0, n_exe = 0, n_orise = 0;
   int unsigned overlap = 0;
   logic        prev_exe = 1'b0, prev_outv = 1'b0;
   logic [7:0]  m_el [4];
   int unsigned m_n = 0;

   always #5 clk = ~clk;

   mx_window_feeder #(
      .DATA_W (DW),
      .IMG_W  (W),
      .IMG_H  (H)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .pix_valid_i     (pix_valid),
      .pix_data_i      (pix_data),
      .pix_ready_o     (pix_ready_o),
      .mx_load_valid_o (mx_load_valid_o),
      .mx_load_data_o  (mx_load_data_o),
      .mx_exe_ready_o  (mx_exe_ready_o),
      .mx_exe_valid_i  (mx_exe_valid),
      .mx_exe_data_i   (mx_exe_data),
      .out_valid_o     (out_valid_o),
      .out_data_o      (out_data_o),
      .out_last_o      (out_last_o),
      .out_ready_i     (out_ready)
   );

   function automatic logic [7:0] smax4(input logic [7:0] a, b, c, d);
      logic signed [7:0] m;
      m = a;
      if ($signed(b) > m) m = b;
      if ($signed(c) > m) m = c;
      if ($signed(d) > m) m = d;
      return m;
   endfunction

   // Pooling unit model plus event recorders, all sampled on the rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pix_valid && pix_ready_o && n_acc < 512) begin
         acc_c[n_acc] <= cyc;
         n_acc        <= n_acc + 1;
      end
      if (mx_load_valid_o && n_load < 512) begin
         load_c[n_load] <= cyc;
         load_d[n_load] <= mx_load_data_o;
         n_load         <= n_load + 1;
         if (mx_exe_ready_o) overlap <= overlap + 1;
      end
      if (mx_exe_ready_o && !prev_exe && n_exe < 512) begin
         exe_c[n_exe] <= cyc;
         n_exe        <= n_exe + 1;
      end
      if (out_valid_o && !prev_outv && n_orise < 512) begin
         orise_c[n_orise] <= cyc;
         n_orise          <= n_orise + 1;
      end
      if (out_valid_o && out_ready && n_out < 512) begin
         out_d[n_out] <= out_data_o;
         out_l[n_out] <= out_last_o;
         n_out        <= n_out + 1;
      end
      prev_exe  <= mx_exe_ready_o;
      prev_outv <= out_valid_o;
      if (rst) begin
         m_n          <= 0;
         mx_exe_valid <= 1'b0;
         mx_exe_data  <= '0;
      end else begin
         if (mx_load_valid_o) begin
            if (m_n < 4) m_el[m_n[1:0]] <= mx_load_data_o;
            m_n <= m_n + 1;
         end
         if (mx_exe_valid) begin
            mx_exe_valid <= 1'b0;
            m_n          <= 0;
         end else if (mx_exe_ready_o && m_n == 4) begin
            mx_exe_valid <= 1'b1;
            mx_exe_data  <= smax4(m_el[0], m_el[1], m_el[2], m_el[3]);
         end
      end
   end

   task automatic do_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_pix(input logic [7:0] d);
      int n = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      while (!pix_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready_o) begin
         n_checks++;
         $display("FAIL pix_accept timeout: ready=%0b required 1", pix_ready_o);
      end
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic feed_map(input map_t px, input int unsigned max_gap);
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         send_pix(px[i]);
      end
   endtask

   task automatic wait_outs(input int unsigned base, input int unsigned n);
      int k = 0;
      while ((n_out - base) < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (30) @(negedge clk);
   endtask

   function automatic map_t ramp_map();
      map_t m;
      for (int i = 0; i < 16; i++) m[i] = 8'(i);
      return m;
   endfunction

   task automatic test_reset();
      logic [7:0] got [7];
      rst = 1'b1;
      repeat (3) @(negedge clk);
      got = '{8'(pix_ready_o), 8'(mx_load_valid_o), mx_load_data_o,
              8'(mx_exe_ready_o), 8'(out_valid_o), out_data_o, 8'(out_last_o)};
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (got[i] !== 8'h00) $display("FAIL reset_out%0d: got %0h required 0", i, got[i]);
         else n_pass++;
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pix_ready_o !== 1'b0) $display("FAIL init_hold: ready=%0b required 0", pix_ready_o);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (pix_ready_o !== 1'b1) $display("FAIL init_exit: ready=%0b required 1", pix_ready_o);
      else n_pass++;
   endtask

   task automatic test_map_basic();
      int unsigned ob, lb, ov;
      logic [7:0] ev [4];
      ev = '{8'd5, 8'd7, 8'd13, 8'd15};
      do_reset();
      out_ready = 1'b1;
      ob = n_out; lb = n_load; ov = overlap;
      feed_map(ramp_map(), 0);
      wait_outs(ob, 4);
      n_checks++;
      if (n_out - ob != 4) $display("FAIL basic_count: got %0d required 4", n_out - ob);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_d[ob+i] !== ev[i]) $display("FAIL basic_data%0d: got %0d required %0d", i, out_d[ob+i], ev[i]);
         else n_pass++;
         n_checks++;
         if (out_l[ob+i] !== (i == 3)) $display("FAIL basic_last%0d: got %0b required %0b", i, out_l[ob+i], (i == 3));
         else n_pass++;
      end
      n_checks++;
      if (n_load - lb != 16) $display("FAIL basic_loads: got %0d required 16", n_load - lb);
      else n_pass++;
      n_checks++;
      if (overlap != ov) $display("FAIL load_exe_overlap: got %0d required %0d", overlap, ov);
      else n_pass++;
   endtask

   task automatic test_timing();
      int unsigned ab, lb, eb, ob, t;
      logic [7:0] el [4];
      el = '{8'd0, 8'd1, 8'd4, 8'd5};
      do_reset();
      out_ready = 1'b1;
      ab = n_acc; lb = n_load; eb = n_exe; ob = n_orise;
      feed_map(ramp_map(), 0);
      wait_outs(n_out, 0);
      t = acc_c[ab+5];
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (load_c[lb+k] != t + 1 + 2*k) $display("FAIL load_cycle%0d: got t+%0d required t+%0d", k, load_c[lb+k] - t, 1 + 2*k);
         else n_pass++;
         n_checks++;
         if (load_d[lb+k] !== el[k]) $display("FAIL load_data%0d: got %0d required %0d", k, load_d[lb+k], el[k]);
         else n_pass++;
      end
      n_checks++;
      if (exe_c[eb] != t + 9) $display("FAIL exe_ready_cycle: got t+%0d required t+9", exe_c[eb] - t);
      else n_pass++;
      n_checks++;
      if (orise_c[ob] != t + 11) $display("FAIL out_valid_cycle: got t+%0d required t+11", orise_c[ob] - t);
      else n_pass++;
      n_checks++;
      if (acc_c[ab+6] != t + 13) $display("FAIL next_accept_cycle: got t+%0d required t+13", acc_c[ab+6] - t);
      else n_pass++;
   endtask

   task automatic test_signed();
      int unsigned ob;
      map_t m;
      logic [7:0] ev [4];
      m  = '{8'hFF, 8'h80, 8'h10, 8'h20,
             8'hFD, 8'hFE, 8'h30, 8'h05,
             8'h81, 8'h90, 8'h7F, 8'h01,
             8'h85, 8'hC0, 8'h80, 8'hFF};
      ev = '{8'hFF, 8'h30, 8'hC0, 8'h7F};
      do_reset();
      out_ready = 1'b1;
      ob = n_out;
      feed_map(m, 0);
      wait_outs(ob, 4);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_d[ob+i] !== ev[i]) $display("FAIL signed_data%0d: got %0h required %0h", i, out_d[ob+i], ev[i]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int unsigned ob, eb, a0;
      logic [7:0] ev [4];
      ev = '{8'd5, 8'd7, 8'd13, 8'd15};
      do_reset();
      out_ready = 1'b0;
      ob = n_out; eb = n_exe;
      for (int i = 0; i < 7; i++) send_pix(8'(i));
      pix_valid = 1'b1;
      pix_data  = 8'd7;
      a0 = n_acc;
      repeat (30) @(negedge clk);
      n_checks++;
      if (n_acc != a0) $display("FAIL bp_stall: accepted %0d required 0", n_acc - a0);
      else n_pass++;
      n_checks++;
      if (n_exe - eb != 1) $display("FAIL bp_exe_ready: got %0d required 1", n_exe - eb);
      else n_pass++;
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 8'd5)
         $display("FAIL bp_hold: valid=%0b data=%0d required 1/5", out_valid_o, out_data_o);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 7; i < 16; i++) send_pix(8'(i));
      wait_outs(ob, 4);
      n_checks++;
      if (n_out - ob != 4) $display("FAIL bp_count: got %0d required 4", n_out - ob);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_d[ob+i] !== ev[i]) $display("FAIL bp_data%0d: got %0d required %0d", i, out_d[ob+i], ev[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_issue();
      int unsigned ob, lb;
      int k = 0;
      logic [7:0] ev [4];
      ev = '{8'd5, 8'd7, 8'd13, 8'd15};
      do_reset();
      out_ready = 1'b1;
      lb = n_load;
      for (int i = 0; i < 6; i++) send_pix(8'(i));
      while (n_load - lb < 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (n_load - lb != 2) $display("FAIL mid_pulses: got %0d required 2", n_load - lb);
      else n_pass++;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid_o !== 1'b0 || mx_load_valid_o !== 1'b0 || mx_exe_ready_o !== 1'b0)
         $display("FAIL mid_reset_outs: out=%0b load=%0b exe=%0b required 0/0/0", out_valid_o, mx_load_valid_o, mx_exe_ready_o);
      else n_pass++;
      rst = 1'b0;
      ob = n_out;
      feed_map(ramp_map(), 0);
      wait_outs(ob, 4);
      n_checks++;
      if (n_out - ob != 4) $display("FAIL mid_count: got %0d required 4", n_out - ob);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_d[ob+i] !== ev[i]) $display("FAIL mid_data%0d: got %0d required %0d", i, out_d[ob+i], ev[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int unsigned ob, lasts;
      map_t rev;
      logic [7:0] ev [8];
      for (int i = 0; i < 16; i++) rev[i] = 8'(15 - i);
      ev = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd15, 8'd13, 8'd7, 8'd5};
      do_reset();
      out_ready = 1'b1;
      ob = n_out;
      feed_map(ramp_map(), 3);
      feed_map(rev, 3);
      wait_outs(ob, 8);
      n_checks++;
      if (n_out - ob != 8) $display("FAIL b2b_count: got %0d required 8", n_out - ob);
      else n_pass++;
      lasts = 0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_d[ob+i] !== ev[i]) $display("FAIL b2b_data%0d: got %0d required %0d", i, out_d[ob+i], ev[i]);
         else n_pass++;
         if (out_l[ob+i] === 1'b1) lasts++;
      end
      n_checks++;
      if (lasts != 2 || out_l[ob+3] !== 1'b1 || out_l[ob+7] !== 1'b1)
         $display("FAIL b2b_last: count=%0d l3=%0b l7=%0b required 2/1/1", lasts, out_l[ob+3], out_l[ob+7]);
      else n_pass++;
   endtask

   initial begin
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      out_ready = 1'b1;
      test_reset();
      test_map_basic();
      test_timing();
      test_signed();
      test_backpressure();
      test_reset_mid_issue();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
